// File: rtl/vmul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vmul_arbiter_if
//  Purpose  : Bundles the requester handshake, the shared-multiplier bus and
//             the tagged result stream of vmul_arbiter.
//             slave  = the arbiter itself.
//             master = the environment (requesters, multiplier, result sink).
//  Revision : 1.0  initial release
// ============================================================================
interface vmul_arbiter_if #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int DW  = 18
);
    // requester side
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] x_i;
    logic [NCH*DW-1:0] x_q;
    logic [NCH*DW-1:0] y_i;
    logic [NCH*DW-1:0] y_q;
    logic [NCH-1:0]    ack;
    logic              hold;
    // multiplier side
    logic [DW-1:0]     mul_x;
    logic [DW-1:0]     mul_y;
    logic              mul_iq;
    logic              mul_gate;
    logic [DW-1:0]     mul_z;
    logic              mul_gate_out;
    // result side
    logic              res_valid;
    logic [CW-1:0]     res_ch;
    logic [DW-1:0]     res_i;
    logic [DW-1:0]     res_q;
    logic              busy;
    logic              err;

    modport slave (
        input  req, x_i, x_q, y_i, y_q, hold, mul_z, mul_gate_out,
        output ack, mul_x, mul_y, mul_iq, mul_gate,
        output res_valid, res_ch, res_i, res_q, busy, err
    );

    modport master (
        output req, x_i, x_q, y_i, y_q, hold, mul_z, mul_gate_out,
        input  ack, mul_x, mul_y, mul_iq, mul_gate,
        input  res_valid, res_ch, res_i, res_q, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/vmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vmul_arbiter
//  Purpose  : Round-robin sharing of one flow-through interleaved-IQ vector
//             multiplier among NCH requesters. Each granted complex pair is
//             issued as I then Q, tagged with its channel, and the I/Q result
//             stream is regrouped into one tagged result word per pair.
//  Revision : 1.0  initial release
// ============================================================================
module vmul_arbiter #(
    parameter int NCH     = 4,
    parameter int CW      = 2,
    parameter int DW      = 18,
    parameter int MUL_LAT = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    vmul_arbiter_if.slave bus
);

    localparam int GW = $clog2(MUL_LAT + 2);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        ISSUE_Q = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   gch, gch_nxt;
    logic [DW-1:0]   qx, qx_nxt;
    logic [DW-1:0]   qy, qy_nxt;
    logic [DW-1:0]   mul_x_nxt, mul_y_nxt;
    logic            mul_iq_nxt, mul_gate_nxt;
    logic [NCH-1:0]  ack_nxt;

    logic            grant_found;
    logic [CW-1:0]   grant_ch;
    int              idx;

    // tag delay line, aligned with the multiplier output
    logic [MUL_LAT-1:0] dl_gate;
    logic [MUL_LAT-1:0] dl_iq;
    logic [CW-1:0]      dl_tag [0:MUL_LAT-1];
    logic               out_gate, out_iq;
    logic [CW-1:0]      out_tag;

    logic [DW-1:0]   held_i;
    logic [CW-1:0]   held_tag;
    logic [GW-1:0]   guard;

    // Round-robin search: first requester at or after ptr, wrapping modulo NCH
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!grant_found && bus.req[idx[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_ch    = idx[CW-1:0];
            end
        end
    end

    // FSM next state and registered multiplier-side outputs
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gch_nxt      = gch;
        qx_nxt       = qx;
        qy_nxt       = qy;
        mul_x_nxt    = bus.mul_x;
        mul_y_nxt    = bus.mul_y;
        mul_iq_nxt   = 1'b0;
        mul_gate_nxt = 1'b0;
        ack_nxt      = '0;
        case (state)
            IDLE: begin
                if (!bus.hold && grant_found) begin
                    gch_nxt           = grant_ch;
                    mul_x_nxt         = bus.x_i[grant_ch*DW +: DW];
                    mul_y_nxt         = bus.y_i[grant_ch*DW +: DW];
                    qx_nxt            = bus.x_q[grant_ch*DW +: DW];
                    qy_nxt            = bus.y_q[grant_ch*DW +: DW];
                    mul_iq_nxt        = 1'b1;
                    mul_gate_nxt      = 1'b1;
                    ack_nxt[grant_ch] = 1'b1;
                    state_nxt         = ISSUE_Q;
                end
            end
            ISSUE_Q: begin
                // Q always follows I, hold cannot split a pair
                mul_x_nxt    = qx;
                mul_y_nxt    = qy;
                mul_gate_nxt = 1'b1;
                ptr_nxt      = (gch == CW'(NCH - 1)) ? '0 : gch + CW'(1);
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and issue-side registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gch          <= '0;
            qx           <= '0;
            qy           <= '0;
            bus.mul_x    <= '0;
            bus.mul_y    <= '0;
            bus.mul_iq   <= 1'b0;
            bus.mul_gate <= 1'b0;
            bus.ack      <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            gch          <= gch_nxt;
            qx           <= qx_nxt;
            qy           <= qy_nxt;
            bus.mul_x    <= mul_x_nxt;
            bus.mul_y    <= mul_y_nxt;
            bus.mul_iq   <= mul_iq_nxt;
            bus.mul_gate <= mul_gate_nxt;
            bus.ack      <= ack_nxt;
        end
    end

    // Delay {gate, iq, tag} by MUL_LAT so it lines up with mul_z
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_gate <= '0;
            dl_iq   <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                dl_tag[k] <= '0;
            end
        end else begin
            dl_gate[0] <= bus.mul_gate;
            dl_iq[0]   <= bus.mul_iq;
            dl_tag[0]  <= gch;
            for (int k = 1; k < MUL_LAT; k++) begin
                dl_gate[k] <= dl_gate[k-1];
                dl_iq[k]   <= dl_iq[k-1];
                dl_tag[k]  <= dl_tag[k-1];
            end
        end
    end

    assign out_gate = dl_gate[MUL_LAT-1];
    assign out_iq   = dl_iq[MUL_LAT-1];
    assign out_tag  = dl_tag[MUL_LAT-1];

    // Regroup: hold the I result, emit the pair when its Q result arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_i        <= '0;
            held_tag      <= '0;
            bus.res_valid <= 1'b0;
            bus.res_ch    <= '0;
            bus.res_i     <= '0;
            bus.res_q     <= '0;
        end else begin
            bus.res_valid <= out_gate & ~out_iq;
            if (out_gate && out_iq) begin
                held_i   <= bus.mul_z;
                held_tag <= out_tag;
            end
            if (out_gate && !out_iq) begin
                bus.res_i  <= held_i;
                bus.res_q  <= bus.mul_z;
                bus.res_ch <= held_tag;
            end
        end
    end

    // Sticky alignment check; the guard masks stale output of the
    // unreset multiplier for MUL_LAT+1 cycles after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            guard   <= GW'(MUL_LAT + 1);
            bus.err <= 1'b0;
        end else begin
            if (guard != '0) begin
                guard <= guard - GW'(1);
            end
            if ((guard == '0) && (out_gate != bus.mul_gate_out)) begin
                bus.err <= 1'b1;
            end
        end
    end

    assign bus.busy = (state == ISSUE_Q) | (|dl_gate);

endmodule
`default_nettype wire

// File: tb/tb_vmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vmul_arbiter
//  Purpose  : Self-checking bench for vmul_arbiter with a behavioural
//             multiplier (truncated product, fixed latency, no reset) and a
//             transaction-level reference model of grants and results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vmul_arbiter;

    localparam int NCH     = 4;
    localparam int CW      = 2;
    localparam int DW      = 18;
    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   late_mode = 1'b0;

    always #5 clk = ~clk;

    vmul_arbiter_if #(.NCH(NCH), .CW(CW), .DW(DW)) bus ();

    vmul_arbiter #(.NCH(NCH), .CW(CW), .DW(DW), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic signed [DW-1:0] mulf(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return p[DW-1:0];
    endfunction

    // shared multiplier model: flow-through, MUL_LAT cycles, not reset
    logic signed [DW-1:0] zp [0:MUL_LAT-1];
    logic                 gp [0:MUL_LAT-1];
    logic                 g_late;

    always @(posedge clk) begin
        zp[0] <= mulf($signed(bus.mul_x), $signed(bus.mul_y));
        gp[0] <= bus.mul_gate;
        for (int k = 1; k < MUL_LAT; k++) begin
            zp[k] <= zp[k-1];
            gp[k] <= gp[k-1];
        end
        g_late <= gp[MUL_LAT-1];
    end

    assign bus.mul_z        = zp[MUL_LAT-1];
    assign bus.mul_gate_out = late_mode ? g_late : gp[MUL_LAT-1];

    // reference model state
    typedef struct {
        int                   due;
        int                   ch;
        logic signed [DW-1:0] ri;
        logic signed [DW-1:0] rq;
    } pair_t;

    typedef struct {
        int ch;
        int xi, xq, yi, yq;
        int ei, eq;
    } vec_t;

    pair_t                sb [$];
    vec_t                 vt [5];
    int                   cyc = 0;
    int                   since_rst = 0;
    bit                   m_busy_q = 1'b0;
    int                   m_ptr = 0;
    int                   m_g = 0;
    logic signed [DW-1:0] m_qx = '0, m_qy = '0;
    logic signed [DW-1:0] e_mx = '0, e_my = '0;
    bit                   e_iq = 1'b0, e_gate = 1'b0, e_err = 1'b0;
    logic [NCH-1:0]       e_ack = '0;
    int                   checks = 0;
    int                   failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_ops(input int k, input int xi, input int xq, input int yi, input int yq);
        bus.x_i[k*DW +: DW] = DW'(xi);
        bus.x_q[k*DW +: DW] = DW'(xq);
        bus.y_i[k*DW +: DW] = DW'(yi);
        bus.y_q[k*DW +: DW] = DW'(yq);
    endtask

    task automatic rand_ops(input int k);
        set_ops(k, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    // One clock: model what the edge must do, then compare the DUT with it
    task automatic step();
        bit                pre_mis;
        logic [NCH-1:0]    rq;
        logic              hd;
        logic              rs;
        logic [NCH*DW-1:0] vxi, vxq, vyi, vyq;
        bit                found;
        bit                exp_v;
        int                c;
        pre_mis = (since_rst >= MUL_LAT + 1) && (bus.mul_gate_out != gp[MUL_LAT-1]);
        rq  = bus.req;
        hd  = bus.hold;
        rs  = rst_n;
        vxi = bus.x_i; vxq = bus.x_q; vyi = bus.y_i; vyq = bus.y_q;
        @(posedge clk);
        cyc++;
        if (!rs) begin
            sb.delete();
            since_rst = 0;
            m_busy_q  = 1'b0;
            m_ptr     = 0;
            e_mx = '0; e_my = '0; e_iq = 1'b0; e_gate = 1'b0; e_err = 1'b0; e_ack = '0;
        end else begin
            if (since_rst < 1000) since_rst++;
            if (pre_mis) e_err = 1'b1;
            e_ack = '0;
            if (m_busy_q) begin
                e_mx = m_qx; e_my = m_qy; e_iq = 1'b0; e_gate = 1'b1;
                m_ptr    = (m_g + 1) % NCH;
                m_busy_q = 1'b0;
            end else begin
                found = 1'b0;
                if (!hd) begin
                    for (int k = 0; k < NCH; k++) begin
                        c = (m_ptr + k) % NCH;
                        if (!found && rq[c]) begin
                            found = 1'b1;
                            m_g   = c;
                        end
                    end
                end
                if (found) begin
                    e_mx = vxi[m_g*DW +: DW]; e_my = vyi[m_g*DW +: DW];
                    m_qx = vxq[m_g*DW +: DW]; m_qy = vyq[m_g*DW +: DW];
                    e_iq = 1'b1; e_gate = 1'b1;
                    e_ack[m_g] = 1'b1;
                    m_busy_q = 1'b1;
                    sb.push_back('{due: cyc + MUL_LAT + 2, ch: m_g,
                                   ri: mulf(e_mx, e_my), rq: mulf(m_qx, m_qy)});
                end else begin
                    e_iq = 1'b0; e_gate = 1'b0;
                end
            end
        end
        #1;
        chk("ack", longint'(bus.ack), longint'(e_ack));
        chk("mul_gate", longint'(bus.mul_gate), longint'(e_gate));
        chk("mul_iq", longint'(bus.mul_iq), longint'(e_iq));
        chk("mul_x", longint'($signed(bus.mul_x)), longint'(e_mx));
        chk("mul_y", longint'($signed(bus.mul_y)), longint'(e_my));
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        chk("res_valid", longint'(bus.res_valid), longint'(exp_v));
        if (exp_v) begin
            chk("res_ch", longint'(bus.res_ch), longint'(sb[0].ch));
            chk("res_i", longint'($signed(bus.res_i)), longint'(sb[0].ri));
            chk("res_q", longint'($signed(bus.res_q)), longint'(sb[0].rq));
            void'(sb.pop_front());
        end
        chk("busy", longint'(bus.busy), longint'(sb.size() > 0));
        chk("err", longint'(bus.err), longint'(e_err));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, longint'(bus.ack), 0);
        chk({tag, "_mul_x"}, longint'(bus.mul_x), 0);
        chk({tag, "_mul_y"}, longint'(bus.mul_y), 0);
        chk({tag, "_mul_gate"}, longint'(bus.mul_gate), 0);
        chk({tag, "_mul_iq"}, longint'(bus.mul_iq), 0);
        chk({tag, "_res_valid"}, longint'(bus.res_valid), 0);
        chk({tag, "_res_ch"}, longint'(bus.res_ch), 0);
        chk({tag, "_res_i"}, longint'(bus.res_i), 0);
        chk({tag, "_res_q"}, longint'(bus.res_q), 0);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_err"}, longint'(bus.err), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int ch, input string nm);
        int n;
        n = 0;
        while (!bus.ack[ch] && n < 20) begin
            step();
            n++;
        end
        chk(nm, longint'(bus.ack[ch]), 1);
    endtask

    task automatic next_grant(output int ch, output int at);
        int n;
        n  = 0;
        ch = -1;
        do begin
            step();
            n++;
        end while (bus.ack == '0 && n < 20);
        at = cyc;
        for (int k = 0; k < NCH; k++) if (bus.ack[k]) ch = k;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int gch [5];
        int gcy [5];
        int n, t0, cnt, ch, at;

        vt[0] = '{ch: 2, xi: 1000,    xq: -2000, yi: 3,    yq: 4,       ei: 3000,    eq: -8000};
        vt[1] = '{ch: 0, xi: 7,       xq: -5,    yi: 11,   yq: 13,      ei: 77,      eq: -65};
        vt[2] = '{ch: 3, xi: -300,    xq: 250,   yi: -200, yq: 100,     ei: 60000,   eq: 25000};
        vt[3] = '{ch: 1, xi: 131071,  xq: -1,    yi: 1,    yq: -131072, ei: 131071,  eq: -131072};
        vt[4] = '{ch: 1, xi: -131072, xq: 0,     yi: -1,   yq: 5,       ei: -131072, eq: 0};

        bus.req = '0; bus.hold = 1'b0;
        bus.x_i = '0; bus.x_q = '0; bus.y_i = '0; bus.y_q = '0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_zero("reset");

        // table: single requests, latency and result word
        for (int i = 0; i < 5; i++) begin
            set_ops(vt[i].ch, vt[i].xi, vt[i].xq, vt[i].yi, vt[i].yq);
            bus.req = NCH'(1) << vt[i].ch;
            wait_ack(vt[i].ch, "tbl_ack");
            t0 = cyc;
            bus.req = '0;
            cnt = 0;
            n = 0;
            while (!bus.res_valid && n < 20) begin
                step();
                n++;
                if (bus.ack != '0) cnt++;
            end
            chk("tbl_ack_once", cnt, 0);
            chk("tbl_latency", cyc - t0, MUL_LAT + 2);
            chk("tbl_res_ch", longint'(bus.res_ch), vt[i].ch);
            chk("tbl_res_i", longint'($signed(bus.res_i)), vt[i].ei);
            chk("tbl_res_q", longint'($signed(bus.res_q)), vt[i].eq);
            repeat (3) step();
        end

        // all four requesting from pointer 0
        do_reset();
        for (int k = 0; k < NCH; k++) rand_ops(k);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            next_grant(ch, at);
            gch[k] = ch;
            gcy[k] = at;
        end
        bus.req = '0;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_ch", gch[k], k % NCH);
            chk("rr_grant_spacing", gcy[k] - gcy[0], 2 * k);
        end
        repeat (10) step();

        // wrap-around after a ch3 grant
        do_reset();
        bus.req = 4'b1000;
        wait_ack(3, "wrap_first_ack3");
        bus.req = 4'b1001;
        next_grant(ch, at);
        chk("wrap_next_ch0", ch, 0);
        next_grant(ch, at);
        chk("wrap_then_ch3", ch, 3);
        bus.req = '0;
        repeat (10) step();

        // hold raised during the Q issue
        bus.req = 4'b0010;
        wait_ack(1, "hold_first_ack");
        bus.hold = 1'b1;
        step();
        chk("hold_q_gate", longint'(bus.mul_gate), 1);
        chk("hold_q_iq", longint'(bus.mul_iq), 0);
        cnt = 0;
        repeat (12) begin
            step();
            if (bus.ack != '0) cnt++;
        end
        chk("hold_no_ack", cnt, 0);
        chk("hold_drained_busy", longint'(bus.busy), 0);
        bus.hold = 1'b0;
        wait_ack(1, "hold_release_ack");
        bus.req = '0;
        repeat (10) step();

        // reset with two pairs in flight
        for (int k = 0; k < NCH; k++) rand_ops(k);
        bus.req = 4'b1111;
        wait_ack(0, "rst_first_ack");
        repeat (3) step();
        bus.req = '0;
        do_reset();
        chk_zero("midrst");
        cnt = 0;
        repeat (12) begin
            step();
            if (bus.res_valid) cnt++;
        end
        chk("midrst_no_result", cnt, 0);
        chk("midrst_err_clear", longint'(bus.err), 0);

        // late gate_out after the guard window
        late_mode = 1'b1;
        set_ops(0, 5, 6, 7, 8);
        bus.req = 4'b0001;
        wait_ack(0, "late_ack");
        bus.req = '0;
        repeat (10) step();
        chk("late_err_set", longint'(bus.err), 1);
        late_mode = 1'b0;
        repeat (10) step();
        chk("late_err_sticky", longint'(bus.err), 1);
        do_reset();
        chk("late_err_reset", longint'(bus.err), 0);
        repeat (8) step();

        // randomized traffic against the model
        for (int k = 0; k < NCH; k++) rand_ops(k);
        for (int t = 0; t < 1500; t++) begin
            step();
            for (int k = 0; k < NCH; k++) begin
                if (bus.ack[k]) begin
                    if ($urandom_range(1, 0) == 0) bus.req[k] = 1'b0;
                    rand_ops(k);
                end else if (!bus.req[k] && $urandom_range(3, 0) == 0) begin
                    rand_ops(k);
                    bus.req[k] = 1'b1;
                end
            end
            bus.hold = ($urandom_range(7, 0) == 0);
        end
        bus.req  = '0;
        bus.hold = 1'b0;
        repeat (12) step();
        chk("rand_all_results_seen", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vmul_arbiter.md
Name: vmul_arbiter

Overview:
- Shares one flow-through interleaved-IQ vector multiplier among NCH requesters.
- Grants requesters round-robin and serialises each granted complex pair onto the multiplier as I then Q.
- Tags every issued pair with its channel and regroups the I/Q result stream into one tagged result word per pair.
- Sits between the per-channel rotation/scaling clients and the single shared multiplier instance.

Parameters:
- NCH, 4: number of requesters (2..8).
- CW, 2: channel tag width, equal to ceil(log2(NCH)).
- DW, 18: sample width (signed).
- MUL_LAT, 4: multiplier latency, in cycles, from input sample to the matching output sample with its gate_out.

Ports:
- clk  in  1  rising-edge clock; all logic is synchronous to it.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NCH  per-channel request; held high until ack.
- x_i, x_q, y_i, y_q  in  NCH*DW each  packed signed operands; channel k occupies bits [k*DW +: DW].
- ack  out  NCH  one-cycle pulse; operands for that channel were sampled on the edge that raised ack.
- hold  in  1  when high, no new grants; a pair already in progress completes.
- mul_x, mul_y  out  DW  multiplier operands (registered).
- mul_iq  out  1  high for the I sample, low for the Q sample.
- mul_gate  out  1  sample valid to the multiplier.
- mul_z  in  DW  multiplier result.
- mul_gate_out  in  1  multiplier's delayed gate.
- res_valid  out  1  one-cycle strobe.
- res_ch  out  CW  channel tag of the result.
- res_i, res_q  out  DW  result pair.
- busy  out  1  high while any pair is in flight (issue state or delay line non-empty).
- err  out  1  sticky alignment error.

Behaviour:
- Reset (rst_n=0 on an edge) clears everything:
  - Outputs: ack, mul_*, res_*, busy and err all go to 0.
  - Internal: state=IDLE, RR pointer=0, tag delay line cleared, guard counter loaded with MUL_LAT+1.
- Reset mid-operation: in-flight pairs are discarded; no res_valid is emitted for them.
- FSM, IDLE:
  - A grant requires hold=0 and req!=0.
  - Grant g = first set req bit at or after the pointer, searching upward and wrapping modulo NCH.
  - On the grant edge: mul_x<=x_i[g], mul_y<=y_i[g], mul_iq<=1, mul_gate<=1, ack[g]<=1.
  - x_q[g] and y_q[g] are latched internally; state->ISSUE_Q.
  - If no grant: mul_gate<=0, mul_iq<=0, mul_x and mul_y hold their values.
- FSM, ISSUE_Q:
  - mul_x/mul_y <= latched Q operands, mul_iq<=0, mul_gate<=1, ack<=0.
  - Pointer <= (g+1) mod NCH; state->IDLE.
- Throughput and ack timing:
  - Peak is one pair per 2 cycles.
  - The next grant decision occurs at the edge after ISSUE_Q, so a requester sees ack before its req is re-evaluated.
  - A channel holding req continuously is re-granted only after every other pending channel has been served.
- hold behaviour: sampled only in IDLE; asserting hold while in ISSUE_Q does not abort the Q issue.
- Tag delay line:
  - {mul_gate, mul_iq, g} is delayed by MUL_LAT cycles, aligned with mul_z and mul_gate_out.
  - Delayed gate & iq: capture mul_z into I holding register and the tag.
  - Delayed gate & !iq: on the next edge, res_i<=held I, res_q<=mul_z, res_ch<=held tag, res_valid<=1 for one cycle.
- Latency: I issued in cycle c → res_valid in cycle c+MUL_LAT+2.
- Arithmetic: results are passed through unmodified; no rounding or saturation here.
- Error check:
  - err is set when delayed gate != mul_gate_out, but only once the guard counter reaches 0.
  - The guard counter decrements every cycle after reset; this masks stale output, since the multiplier has no reset.
  - err is cleared only by reset.
- busy = (state==ISSUE_Q) | (OR of the delayed-gate bits in the delay line).

Test Plan:
- Single request, ch2 only, x=(1000,-2000), y=(3,4) → ack[2] pulses once; mul_gate high for 2 cycles with mul_iq=1 then 0; res_valid at c+6 with res_ch=2; res_i and res_q equal the multiplier model's outputs.
- req=4'b1111 held, pointer=0 → grants 0,1,2,3,0 on cycles c, c+2, c+4, c+6, c+8; results emitted in the same order, 2 cycles apart.
- req=4'b1001 held after a ch3 grant → next grant is ch0 (wrap-around), then ch3.
- hold=1 raised in the ISSUE_Q cycle → Q still issued; no further ack until hold=0; busy drops after the pipeline drains.
- rst_n=0 for 1 cycle while 2 pairs are in flight → no res_valid for them; all outputs 0; err stays 0 even though the model emits gate_out during the guard window.
- Model gate_out forced 1 cycle late after the guard window → err=1 and remains set until reset.
